// File: rtl/cordic_seq_pkg.sv
// Shared types and constants for the CORDIC request/response sequencer.
package cordic_seq_pkg;

  localparam int IN_W            = 10;
  localparam int OUT_W           = 11;
  localparam int CORDIC_DONE_LAT = 5;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    RD_A,
    RD_B,
    HOLD
  } seq_state_t;

  typedef struct packed {
    logic req_ready;
    logic cdc_rst;
    logic out_toggle;
    logic res_valid;
  } seq_out_t;

  // Moore outputs for a given state; loaded together with the state register.
  function automatic seq_out_t decode_outputs(seq_state_t s);
    seq_out_t o;
    o            = '0;
    o.req_ready  = (s == IDLE);
    o.cdc_rst    = (s inside {IDLE, CLR, HOLD});
    o.out_toggle = (s == RD_A);
    o.res_valid  = (s == HOLD);
    return o;
  endfunction

endpackage

// File: rtl/cordic_sequencer.sv
// Turns the one-shot CORDIC core into a request/response engine: re-arm the core,
// wait for done (with timeout), read both output words, hold the result.
module cordic_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int RST_CYCLES     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [IN_W-1:0]  req_val,
  output logic             cdc_rst,
  output logic             cdc_mode,
  output logic             cdc_out_toggle,
  output logic [IN_W-1:0]  cdc_in_val,
  input  logic [OUT_W-1:0] cdc_val,
  input  logic             cdc_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_a,
  output logic [OUT_W-1:0] res_b,
  output logic             res_mode,
  output logic             res_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  seq_state_t    state;
  seq_out_t      outs;
  logic [TW-1:0] timer;
  logic [CW-1:0] clr_cnt;

  assign req_ready      = outs.req_ready;
  assign cdc_rst        = outs.cdc_rst;
  assign cdc_out_toggle = outs.out_toggle;
  assign res_valid      = outs.res_valid;

  // Every transition reloads the output register from the state being entered,
  // so the core reset and output select are registered yet aligned with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      outs       <= decode_outputs(IDLE);
      cdc_mode   <= 1'b0;
      cdc_in_val <= '0;
      timer      <= '0;
      clr_cnt    <= '0;
      res_a      <= '0;
      res_b      <= '0;
      res_mode   <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cdc_mode   <= req_mode;
            cdc_in_val <= req_val;
            clr_cnt    <= '0;
            state      <= CLR;
            outs       <= decode_outputs(CLR);
          end
        end
        CLR: begin
          if (int'(clr_cnt) >= RST_CYCLES - 1) begin
            timer <= '0;
            state <= RUN;
            outs  <= decode_outputs(RUN);
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          if (int'(timer) < TIMEOUT_CYCLES) timer <= timer + 1'b1;
          // A done seen on the timeout cycle still wins.
          if (cdc_done) begin
            state <= RD_A;
            outs  <= decode_outputs(RD_A);
          end else if (int'(timer) >= TIMEOUT_CYCLES) begin
            res_a    <= '0;
            res_b    <= '0;
            res_mode <= cdc_mode;
            res_err  <= 1'b1;
            state    <= HOLD;
            outs     <= decode_outputs(HOLD);
          end
        end
        RD_A: begin
          res_a <= cdc_val;
          state <= RD_B;
          outs  <= decode_outputs(RD_B);
        end
        RD_B: begin
          res_b    <= cdc_val;
          res_mode <= cdc_mode;
          res_err  <= 1'b0;
          state    <= HOLD;
          outs     <= decode_outputs(HOLD);
        end
        HOLD: begin
          if (res_ready) begin
            state <= IDLE;
            outs  <= decode_outputs(IDLE);
          end
        end
        default: begin
          state <= IDLE;
          outs  <= decode_outputs(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Directed bench for cordic_sequencer with a behavioural core stub whose output
// words encode {mode, in_val} so capture, ordering and latching are all visible.
module tb_cordic_sequencer;
  import cordic_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_mode = 1'b0;
  logic [IN_W-1:0]  req_val = '0;
  logic             cdc_rst;
  logic             cdc_mode;
  logic             cdc_out_toggle;
  logic [IN_W-1:0]  cdc_in_val;
  logic [OUT_W-1:0] cdc_val;
  logic             cdc_done = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [OUT_W-1:0] res_a;
  logic [OUT_W-1:0] res_b;
  logic             res_mode;
  logic             res_err;

  int n_vec = 0;
  int n_err = 0;

  int stub_lat  = CORDIC_DONE_LAT;
  bit stub_hang = 1'b0;
  int stub_cnt  = 0;

  cordic_sequencer #(.TIMEOUT_CYCLES(15), .RST_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_val(req_val),
    .cdc_rst(cdc_rst), .cdc_mode(cdc_mode), .cdc_out_toggle(cdc_out_toggle),
    .cdc_in_val(cdc_in_val), .cdc_val(cdc_val), .cdc_done(cdc_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_a(res_a), .res_b(res_b),
    .res_mode(res_mode), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Core stub: done rises stub_lat edges after reset release; word A = {mode,in_val}, word B = its inverse.
  always @(posedge clk) begin
    if (cdc_rst) begin
      stub_cnt <= 0;
      cdc_done <= 1'b0;
    end else begin
      if (stub_cnt < 100) stub_cnt <= stub_cnt + 1;
      cdc_done <= !stub_hang && (stub_cnt + 1 >= stub_lat);
    end
  end
  assign cdc_val = cdc_out_toggle ? {cdc_mode, cdc_in_val} : ~{cdc_mode, cdc_in_val};

  typedef struct {
    logic            mode;
    logic [IN_W-1:0] val;
    int              lat;
    bit              hang;
    logic [OUT_W-1:0] exp_a;
    logic [OUT_W-1:0] exp_b;
    logic            exp_err;
    int              exp_edges;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic waitResult(input logic mode, input logic [IN_W-1:0] val,
                            output int edges, output int fall, output bit stable);
    edges  = -1;
    fall   = -1;
    stable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (fall < 0 && !cdc_rst) fall = k;
      if (cdc_mode !== mode || cdc_in_val !== val) stable = 1'b0;
      if (res_valid) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic mode, input logic [IN_W-1:0] val,
                               output int edges, output int fall, output bit stable);
    req_mode  = mode;
    req_val   = val;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waitResult(mode, val, edges, fall, stable);
  endtask

  task automatic handOff();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges, fall;
    bit stable, bp_ok, quiet;
    logic [OUT_W-1:0] held_a, held_b;

    vecs[0] = '{1'b0, 10'h000, 5,  1'b0, 11'h000, 11'h7FF, 1'b0, 9};
    vecs[1] = '{1'b0, 10'h065, 5,  1'b0, 11'h065, 11'h79A, 1'b0, 9};
    vecs[2] = '{1'b1, 10'h108, 5,  1'b0, 11'h508, 11'h2F7, 1'b0, 9};
    vecs[3] = '{1'b0, 10'h2AA, 5,  1'b1, 11'h000, 11'h000, 1'b1, 17};
    vecs[4] = '{1'b1, 10'h3FF, 5,  1'b0, 11'h7FF, 11'h000, 1'b0, 9};
    vecs[5] = '{1'b0, 10'h155, 15, 1'b0, 11'h155, 11'h6AA, 1'b0, 19};
    vecs[6] = '{1'b1, 10'h0AA, 16, 1'b0, 11'h000, 11'h000, 1'b1, 17};
    vecs[7] = '{1'b0, 10'h001, 3,  1'b0, 11'h001, 11'h7FE, 1'b0, 7};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_cdc_rst", cdc_rst, 1);
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_cdc_in_val", cdc_in_val, 0);
    checkOutput("reset_res_err", res_err, 0);

    foreach (vecs[i]) begin
      stub_lat  = vecs[i].lat;
      stub_hang = vecs[i].hang;
      checkOutput($sformatf("v%0d_idle_ready", i), req_ready, 1);
      applyStimulus(vecs[i].mode, vecs[i].val, edges, fall, stable);
      checkOutput($sformatf("v%0d_latency", i), edges, vecs[i].exp_edges);
      checkOutput($sformatf("v%0d_rst_fall", i), fall, 1);
      checkOutput($sformatf("v%0d_req_stable", i), stable, 1);
      checkOutput($sformatf("v%0d_res_a", i), res_a, vecs[i].exp_a);
      checkOutput($sformatf("v%0d_res_b", i), res_b, vecs[i].exp_b);
      checkOutput($sformatf("v%0d_res_mode", i), res_mode, vecs[i].mode);
      checkOutput($sformatf("v%0d_res_err", i), res_err, vecs[i].exp_err);
      handOff();
      checkOutput($sformatf("v%0d_after_handoff", i), {req_ready, res_valid}, 2'b10);
    end

    // Back-pressure: result must hold and a waiting request must not slip in early.
    stub_lat  = CORDIC_DONE_LAT;
    stub_hang = 1'b0;
    applyStimulus(1'b1, 10'h0F0, edges, fall, stable);
    checkOutput("bp_latency", edges, 9);
    held_a    = 11'h4F0;
    held_b    = 11'h30F;
    req_mode  = 1'b0;
    req_val   = 10'h00F;
    req_valid = 1'b1;
    bp_ok     = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (!res_valid || req_ready || res_a !== held_a || res_b !== held_b ||
          res_mode !== 1'b1 || res_err !== 1'b0 || cdc_in_val !== 10'h0F0 || cdc_mode !== 1'b1)
        bp_ok = 1'b0;
    end
    checkOutput("bp_hold_stable", bp_ok, 1);
    handOff();
    checkOutput("bp_no_accept_at_handoff", {req_ready, cdc_in_val}, {1'b1, 10'h0F0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("bp_accept_next", {req_ready, cdc_in_val}, {1'b0, 10'h00F});
    waitResult(1'b0, 10'h00F, edges, fall, stable);
    checkOutput("bp2_latency", edges, 9);
    checkOutput("bp2_res_a", res_a, 11'h00F);
    checkOutput("bp2_res_b", res_b, 11'h7F0);
    handOff();

    // Reset pulse while the core is running discards everything.
    req_mode  = 1'b1;
    req_val   = 10'h3FF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_in_run", cdc_rst, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid_rst_req_ready", req_ready, 1);
    checkOutput("mid_rst_cdc_rst", cdc_rst, 1);
    checkOutput("mid_rst_cdc_mode", cdc_mode, 0);
    checkOutput("mid_rst_cdc_in_val", cdc_in_val, 0);
    checkOutput("mid_rst_toggle", cdc_out_toggle, 0);
    checkOutput("mid_rst_res_valid", res_valid, 0);
    checkOutput("mid_rst_res_a", res_a, 0);
    checkOutput("mid_rst_res_b", res_b, 0);
    checkOutput("mid_rst_res_mode", res_mode, 0);
    checkOutput("mid_rst_res_err", res_err, 0);
    quiet = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (res_valid || !cdc_rst || !req_ready) quiet = 1'b0;
    end
    checkOutput("mid_rst_stays_idle", quiet, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_sequencer.md
# cordic_sequencer

Control block directly upstream of the CORDIC unit (`tt_um_cordic_wrapper`). The CORDIC core is one-shot: it runs once after reset and then holds its result. This block turns it into a request/response engine. It accepts one request through a valid/ready handshake, re-arms the core by pulsing its reset, and waits for `done`. It then reads both output words by toggling the core's output select and returns them as a registered result with a valid/ready handshake.

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum number of RUN cycles spent waiting for `cdc_done` before the request is aborted with an error.
- `RST_CYCLES`, default 1: number of cycles `cdc_rst` is held in CLR after a new request is latched. Legal range is ≥1.
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  a request is present.
- `req_ready`  out  1  the block can accept a request; high only in IDLE.
- `req_mode`  in  1  0 = rotation (sin/cos), 1 = vectoring (atan).
- `req_val`  in  10  operand. In rotation it is an angle in rad·128. In vectoring it is {x[4:0], y[4:0]}.
- `cdc_rst`  out  1  reset to the CORDIC core.
- `cdc_mode`  out  1  drives the core's `mode_toggle`.
- `cdc_out_toggle`  out  1  drives the core's `out_toggle`.
- `cdc_in_val`  out  10  drives the core's `in_val`.
- `cdc_val`  in  11  core output word (signed).
- `cdc_done`  in  1  core done flag.
- `res_valid`  out  1  a result is held.
- `res_ready`  in  1  the consumer takes the result.
- `res_a`  out  11  signed. Holds sin·512 in rotation, atan·512 in vectoring.
- `res_b`  out  11  signed. Holds cos·512 in rotation, the scaled vector magnitude in vectoring.
- `res_mode`  out  1  mode of the held result.
- `res_err`  out  1  the request timed out; `res_a` and `res_b` are 0.

## Operation
- States: IDLE, CLR, RUN, RD_A, RD_B, HOLD.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `req_mode` and `req_val` into `cdc_mode` and `cdc_in_val`, then go to CLR.
- CLR:
  - Count `RST_CYCLES` cycles, then go to RUN.
  - The RUN timer is cleared on entry to RUN.
- RUN:
  - Increment the timer each cycle.
  - If `cdc_done`=1, go to RD_A. `cdc_done` has priority over timeout when both happen in the same cycle.
  - Otherwise, if the timer reaches `TIMEOUT_CYCLES`, clear `res_a` and `res_b`, set `res_err`=1, and go to HOLD.
- RD_A: `cdc_out_toggle`=1. At the end of the cycle, capture `cdc_val` into `res_a`, then go to RD_B.
- RD_B: `cdc_out_toggle`=0. At the end of the cycle, capture `cdc_val` into `res_b`, set `res_err`=0, then go to HOLD.
- HOLD:
  - `res_valid`=1.
  - On `res_ready`, go to IDLE.
  - `res_*` stay stable while `res_valid` & !`res_ready`.
- `cdc_rst` is registered. It is 1 in IDLE, CLR and HOLD, and 0 in RUN, RD_A and RD_B.
- `cdc_mode` and `cdc_in_val` are held constant from the accept edge until HOLD is exited. The core samples `in_val` at its first step and uses `mode` in every step.
- `cdc_out_toggle` is registered and decoded from the next state, so the core's output mux is settled within the RD cycle.
- Results are copied bit-for-bit. No rescaling or sign handling is applied.
- The timer is a $clog2(`TIMEOUT_CYCLES`+1)-bit counter and saturates; it does not wrap.
- A new request is never accepted in the same cycle as a result hand-off. HOLD→IDLE costs one cycle.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `cdc_rst`=1, `cdc_mode`=0, `cdc_in_val`=0, `cdc_out_toggle`=0, `res_valid`=0, `res_a`=0, `res_b`=0, `res_mode`=0, `res_err`=0.
- `rst` asserted mid-operation returns the block to IDLE on the next edge. The core is held in reset and any partial result is discarded.
- With the accept edge as E0, `cdc_rst` falls at E(`RST_CYCLES`). The core asserts `done` 5 edges later, and RUN samples it on the following edge.
- `res_valid` rises at E(8+`RST_CYCLES`), which is E9 with the default `RST_CYCLES`.
- Throughput is one result per 10+`RST_CYCLES` cycles when `res_ready` is tied high.
- A timeout yields `res_valid` at E(`RST_CYCLES`+`TIMEOUT_CYCLES`+1).

## Structure
- Package `cordic_seq_pkg` holds:
  - the state enum `seq_state_t`;
  - `IN_W`=10 and `OUT_W`=11;
  - `CORDIC_DONE_LAT`=5, the core's done latency after reset release.
- The block is a single module with no sub-module. The timer is inline.

## Test plan
- Rotation, `req_val`=0 against the real core: `res_valid` at E9; `res_a` within ±3 of 0; `res_b` within ±3 of 512; `res_err`=0.
- Rotation, `req_val`=101 (π/4): `res_a` and `res_b` each within ±3 of 362. `cdc_in_val` and `cdc_mode` remain stable from E0 until the result is accepted.
- Vectoring, `req_val`={5'd8, 5'd8}: `res_a` within ±3 of 402 (π/4·512); `res_mode`=1.
- Core stub that never asserts `done`: `res_valid` at E17 with `res_err`=1 and `res_a`=`res_b`=0. A following good request completes normally with `res_err`=0.
- Back-pressure, `res_ready` held low for 20 cycles: `res_*` are stable, `req_ready`=0, and a second `req_valid` is not accepted until one cycle after the hand-off.
- `rst` pulsed while in RUN: the next edge gives IDLE and all reset values; `cdc_rst`=1; no `res_valid` pulse.
